isp_stream_to_sync: RTL and testbench
=====================================

ISP_STREAM_TO_SYNC -- requirements
Module: isp_stream_to_sync

Interface
REQ-001 The block SHALL have parameter COLOR_DEPTH, default 8, bits per colour channel of the pixel word.
REQ-002 The block SHALL have parameter HBLANK_CYCLES, default 16, number of hsync-low cycles inserted after each line (minimum 1).
REQ-003 The block SHALL have parameter FSYNC_CYCLES, default 32, number of fsync-high cycles inserted after each frame (minimum 1).
REQ-004 clk  input  1  the single clock; all logic is in this domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 out_ready  output  1  this block accepts the upstream beat; a transfer occurs when in_valid and out_ready are both 1.
REQ-008 in_data  input  3*COLOR_DEPTH  upstream pixel.
REQ-009 in_user  input  8  upstream sideband: [0] hstart (first pixel of a line), [1] fstart (first pixel of a frame); other bits are ignored.
REQ-010 pixel_x  input  16  active pixels per line.
REQ-011 pixel_y  input  16  active lines per frame.
REQ-012 out_valid  output  1  output pixel valid.
REQ-013 out_data  output  3*COLOR_DEPTH  output pixel.
REQ-014 out_fsync  output  1  high between frames, low during a frame.
REQ-015 out_hsync  output  1  high for the whole of an active line, low otherwise.
REQ-016 err_sync  output  1  one-cycle pulse on a protocol violation.

Function
REQ-017 The block SHALL implement the states IDLE, LINE, HBLANK, LWAIT and FSYNC.
REQ-018 All outputs except out_ready SHALL be registered, and an accepted beat SHALL appear on out_data/out_valid exactly one cycle after acceptance.
REQ-019 out_ready SHALL be 1 in IDLE, LINE and LWAIT, and 0 in HBLANK and FSYNC.
REQ-020 In IDLE, out_fsync=1 and out_hsync=0; accepted beats without fstart SHALL be dropped silently.
REQ-021 In IDLE, an accepted beat with fstart SHALL sample pixel_x and pixel_y (a value of 0 is treated as 1), set row=0 and col=1, and output that pixel with out_fsync=0 and out_hsync=1; the next state is LINE.
REQ-022 In LINE, each accepted beat SHALL be output with out_hsync=1 and col SHALL increment.
REQ-023 In LINE, a cycle with no accepted beat SHALL give out_valid=0 while out_hsync stays 1.
REQ-024 When the beat accepted makes col equal the sampled pixel_x, row SHALL increment; the next state is HBLANK if row<pixel_y, else FSYNC.
REQ-025 In HBLANK, out_hsync=0 and out_valid=0 for HBLANK_CYCLES cycles, then the next state is LWAIT.
REQ-026 In LWAIT, out_hsync=0; an accepted beat with hstart SHALL be output with out_hsync=1, set col=1, and move to LINE.
REQ-027 In LWAIT, an accepted beat without hstart or fstart SHALL be dropped and SHALL pulse err_sync.
REQ-028 In FSYNC, out_fsync=1, out_hsync=0 and out_valid=0 for FSYNC_CYCLES cycles, then the next state is IDLE.
REQ-029 In LINE or LWAIT, an accepted beat with fstart SHALL pulse err_sync and be treated as the REQ-021 frame start; out_fsync stays 0.
REQ-030 In LINE, an accepted beat with hstart (without fstart) and col>0 SHALL pulse err_sync and be dropped; the line ends early, row increments, and the next state follows REQ-024.
REQ-031 col and row SHALL be 16 bits wide; changes to pixel_x and pixel_y mid-frame SHALL have no effect until the next frame start.
REQ-032 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-033 While reset=1, the block SHALL be in state IDLE with col=row=0 and counters cleared, and SHALL drive out_valid=0, out_data=0, out_fsync=1, out_hsync=0, err_sync=0, and out_ready=0.
REQ-034 After reset is released, out_ready SHALL be 1 on the first cycle and the block SHALL wait for fstart.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no partial-line completion.

Verification
REQ-036 Nominal frame: pixel_x=4, pixel_y=2, HBLANK=2, FSYNC=3, continuous valid, proper hstart/fstart -> 4 pixels with hsync=1, 2 cycles hsync=0, 4 pixels, 3 cycles fsync=1, then IDLE; err_sync never pulses.
REQ-037 Upstream gaps: in_valid toggles 1010 within a line -> out_valid mirrors it one cycle later and out_hsync stays 1 across the gaps; pixel order is preserved.
REQ-038 Early fstart: fstart at col=2 of row 1 -> err_sync pulses once, row resets to 0, out_fsync stays 0, and the new frame outputs normally.
REQ-039 Junk before frame: 5 beats without fstart in IDLE -> no output and no err_sync; the 6th beat, with fstart, is output with hsync=1 and fsync=0.
REQ-040 Missing hstart: beat without hstart in LWAIT -> dropped and err_sync=1 for one cycle; the next beat with hstart starts the line.
REQ-041 Reset mid-line: reset asserted at col=2 -> out_valid=0, out_hsync=0 and out_fsync=1 asynchronously; after release the block waits for fstart.

Source files
------------

// File: rtl/isp_stream_to_sync.sv
// rtl/isp_stream_to_sync.sv - ready/valid pixel stream to fsync/hsync framed output
module isp_stream_to_sync #(
    parameter int COLOR_DEPTH   = 8,
    parameter int HBLANK_CYCLES = 16,
    parameter int FSYNC_CYCLES  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       out_ready,
    input  logic [3*COLOR_DEPTH-1:0]   in_data,
    input  logic [7:0]                 in_user,
    input  logic [15:0]                pixel_x,
    input  logic [15:0]                pixel_y,
    output logic                       out_valid,
    output logic [3*COLOR_DEPTH-1:0]   out_data,
    output logic                       out_fsync,
    output logic                       out_hsync,
    output logic                       err_sync
);

    localparam logic [15:0] HB_LAST = 16'(HBLANK_CYCLES - 1);
    localparam logic [15:0] FS_LAST = 16'(FSYNC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE,
        S_HBLANK,
        S_LWAIT,
        S_FSYNC
    } state_t;

    state_t      state;
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] px_q;
    logic [15:0] py_q;
    logic [15:0] cnt;

    logic        accept;
    logic        hstart;
    logic        fstart;
    logic        frame_start;
    logic        take_beat;
    logic        early_end;
    logic        err_ev;
    logic        line_done;
    logic        last_line;
    logic [15:0] start_px;
    logic [15:0] start_py;
    logic [15:0] line_px;
    logic [15:0] line_py;
    logic [15:0] row_base;
    logic [15:0] col_new;
    logic [15:0] row_inc;
    logic        unused_user_bits;

    // Backpressure only during the generated blanking intervals and while in reset.
    assign out_ready = !reset && (state == S_IDLE || state == S_LINE || state == S_LWAIT);
    assign accept    = in_valid && out_ready;

    assign hstart           = in_user[0];
    assign fstart           = in_user[1];
    assign unused_user_bits = ^in_user[7:2];

    // fstart always restarts the frame, wherever it is accepted.
    assign frame_start = accept && fstart;

    // Beats that become output pixels.
    assign take_beat = frame_start
                    || (accept && state == S_LINE  && !hstart)
                    || (accept && state == S_LWAIT &&  hstart);

    // Unexpected hstart in the middle of a line closes that line short.
    assign early_end = accept && state == S_LINE && hstart && !fstart;

    assign err_ev = (accept && fstart && (state == S_LINE || state == S_LWAIT))
                 || early_end
                 || (accept && state == S_LWAIT && !hstart && !fstart);

    // Zero-sized geometry is clamped to one so a line/frame always terminates.
    assign start_px = (pixel_x == 16'd0) ? 16'd1 : pixel_x;
    assign start_py = (pixel_y == 16'd0) ? 16'd1 : pixel_y;

    // On a frame start the freshly sampled geometry applies to this very beat.
    assign line_px  = frame_start ? start_px : px_q;
    assign line_py  = frame_start ? start_py : py_q;
    assign row_base = frame_start ? 16'd0 : row;
    assign col_new  = (frame_start || state == S_LWAIT) ? 16'd1 : col + 16'd1;
    assign row_inc  = row_base + 16'd1;

    assign line_done = (col_new == line_px);
    assign last_line = !(row_inc < line_py);

    // Framing FSM: blanking defaults per state, then accepted-beat overrides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            col       <= 16'd0;
            row       <= 16'd0;
            px_q      <= 16'd0;
            py_q      <= 16'd0;
            cnt       <= 16'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_fsync <= 1'b1;
            out_hsync <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_sync  <= err_ev;

            case (state)
                S_IDLE: begin
                    out_fsync <= 1'b1;
                    out_hsync <= 1'b0;
                end
                S_LINE: begin
                    out_fsync <= 1'b0;
                    out_hsync <= 1'b1;
                end
                S_LWAIT: begin
                    out_fsync <= 1'b0;
                    out_hsync <= 1'b0;
                end
                S_HBLANK: begin
                    out_fsync <= 1'b0;
                    out_hsync <= 1'b0;
                    if (cnt == HB_LAST) begin
                        state <= S_LWAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_FSYNC: begin
                    out_fsync <= 1'b1;
                    out_hsync <= 1'b0;
                    if (cnt == FS_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (take_beat) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_fsync <= 1'b0;
                out_hsync <= 1'b1;
                col       <= col_new;
                if (frame_start) begin
                    px_q <= start_px;
                    py_q <= start_py;
                end
                if (line_done) begin
                    row   <= row_inc;
                    cnt   <= 16'd0;
                    state <= last_line ? S_FSYNC : S_HBLANK;
                end else begin
                    row   <= row_base;
                    state <= S_LINE;
                end
            end else if (early_end) begin
                out_hsync <= 1'b0;
                row       <= row_inc;
                cnt       <= 16'd0;
                state     <= last_line ? S_FSYNC : S_HBLANK;
            end
        end
    end

endmodule

// File: tb/tb_isp_stream_to_sync.sv
// tb/tb_isp_stream_to_sync.sv - directed bench for isp_stream_to_sync
module tb_isp_stream_to_sync;

    localparam int CD = 8;
    localparam int HB = 2;
    localparam int FS = 3;

    localparam logic [7:0] U_NONE = 8'h00;
    localparam logic [7:0] U_HS   = 8'h01;
    localparam logic [7:0] U_FS   = 8'h03;
    localparam logic [7:0] U_JUNK = 8'hFC;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            out_ready;
    logic [3*CD-1:0] in_data;
    logic [7:0]      in_user;
    logic [15:0]     pixel_x;
    logic [15:0]     pixel_y;
    logic            out_valid;
    logic [3*CD-1:0] out_data;
    logic            out_fsync;
    logic            out_hsync;
    logic            err_sync;

    int              errors = 0;
    int              checks = 0;
    logic [3*CD-1:0] last_data;

    always #5 clk = ~clk;

    isp_stream_to_sync #(
        .COLOR_DEPTH   (CD),
        .HBLANK_CYCLES (HB),
        .FSYNC_CYCLES  (FS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_user   (in_user),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fsync (out_fsync),
        .out_hsync (out_hsync),
        .err_sync  (err_sync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags are packed as {valid, hsync, fsync, err}.
    task automatic check_outputs(input string tag, input logic ev, input logic eh,
                                 input logic ef, input logic ee);
        check({tag, "/flags"}, {28'd0, out_valid, out_hsync, out_fsync, err_sync},
              {28'd0, ev, eh, ef, ee});
        check({tag, "/data"}, 32'(out_data), 32'(last_data));
    endtask

    // Drive one cycle of input, check ready before the edge and outputs after it.
    task automatic step(input string tag, input logic v, input logic [3*CD-1:0] d,
                        input logic [7:0] u, input logic er, input logic ev,
                        input logic eh, input logic ef, input logic ee);
        in_valid = v;
        in_data  = d;
        in_user  = u;
        check({tag, "/ready"}, 32'(out_ready), 32'(er));
        @(posedge clk);
        #1;
        if (ev) last_data = d;
        check_outputs(tag, ev, eh, ef, ee);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_user   = U_NONE;
        pixel_x   = 16'd4;
        pixel_y   = 16'd2;
        last_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst/ready", 32'(out_ready), 32'd0);
        check_outputs("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("rel/ready", 32'(out_ready), 32'd1);

        // Junk before frame: dropped silently, ignored user bits do not matter
        for (int i = 0; i < 5; i++)
            step("junk", 1'b1, 24'h0F0F00 + 24'(i), U_JUNK, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Nominal frame 4x2, continuous valid
        step("a1", 1'b1, 24'hA00001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("a2", 1'b1, 24'hA00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("a3", 1'b1, 24'hA00003, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("a4", 1'b1, 24'hA00004, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("hb1", 1'b1, 24'hB00001, U_HS,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hb2", 1'b1, 24'hB00001, U_HS,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("b1", 1'b1, 24'hB00001, U_HS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("b2", 1'b1, 24'hB00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("b3", 1'b1, 24'hB00003, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("b4", 1'b1, 24'hB00004, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FS; i++)
            step("fs_a", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Upstream gaps within a single-line frame
        pixel_x = 16'd4;
        pixel_y = 16'd1;
        step("c1", 1'b1, 24'hC00001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cg1", 1'b0, 24'hDEAD01, U_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("c2", 1'b1, 24'hC00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cg2", 1'b0, 24'hDEAD02, U_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("c3", 1'b1, 24'hC00003, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("c4", 1'b1, 24'hC00004, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FS; i++)
            step("fs_c", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Early fstart in row 1; pixel_x changed mid-frame must not shorten line 0
        pixel_x = 16'd4;
        pixel_y = 16'd2;
        step("d1", 1'b1, 24'hD00001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pixel_x = 16'd7;
        step("d2", 1'b1, 24'hD00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("d3", 1'b1, 24'hD00003, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("d4", 1'b1, 24'hD00004, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("hb_d1", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hb_d2", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("e1", 1'b1, 24'hE00001, U_HS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("e2", 1'b1, 24'hE00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pixel_x = 16'd2;
        pixel_y = 16'd1;
        step("f1", 1'b1, 24'hF00001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("f2", 1'b1, 24'hF00002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FS; i++)
            step("fs_f", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Missing hstart in LWAIT
        pixel_x = 16'd2;
        pixel_y = 16'd2;
        step("g1", 1'b1, 24'h600001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("g2", 1'b1, 24'h600002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("hb_g1", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hb_g2", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("g3", 1'b1, 24'h600003, U_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("g_gap", 1'b0, 24'h000000, U_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("h1", 1'b1, 24'h700001, U_HS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("h2", 1'b1, 24'h700002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FS; i++)
            step("fs_h", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-line at col=2 takes effect without a clock edge
        pixel_x = 16'd4;
        pixel_y = 16'd2;
        step("j1", 1'b1, 24'h900001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("j2", 1'b1, 24'h900002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid  = 1'b0;
        reset     = 1'b1;
        last_data = '0;
        #1;
        check("rst_mid/ready", 32'(out_ready), 32'd0);
        check_outputs("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        step("k0", 1'b1, 24'h800000, U_HS,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("k1", 1'b1, 24'h800001, U_FS,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("k2", 1'b1, 24'h800002, U_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Early hstart mid-line: dropped, err pulse, line closes into HBLANK
        step("k3", 1'b1, 24'h800003, U_HS,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("hb_k", 1'b0, 24'h000000, U_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
